// File: rtl/batch_scheduler.sv
// batch_scheduler
//
// Collects matrix-size jobs from a host into a small queue, then on
// batch_go copies the queue into the accelerator instruction memory
// (one word per job plus a zero terminator), pulses ap_start and waits
// for ap_done. A watchdog aborts the batch if the accelerator does not
// answer within TIMEOUT_CYCLES.
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   job_valid, job_size   host job offer
//   job_ready             job accepted when job_valid & job_ready at clk
//   batch_go              launch the queued batch
//   addrI, enI, dataI     instruction-memory write port
//   ap_start, ap_done     accelerator handshake
//   busy                  high whenever the scheduler is not idle
//   batch_done            one-cycle completion pulse
//   timeout_err           sticky watchdog abort flag
//   job_count             number of queued jobs
//   bad_job               sticky flag: a zero-size job was offered
module batch_scheduler #(
    parameter int INPUT_WIDTH    = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int MAX_JOBS       = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           job_valid,
    input  logic [INPUT_WIDTH-1:0]         job_size,
    output logic                           job_ready,
    input  logic                           batch_go,
    output logic [ADDR_WIDTH-1:0]          addrI,
    output logic                           enI,
    output logic [INPUT_WIDTH-1:0]         dataI,
    output logic                           ap_start,
    input  logic                           ap_done,
    output logic                           busy,
    output logic                           batch_done,
    output logic                           timeout_err,
    output logic [$clog2(MAX_JOBS+1)-1:0]  job_count,
    output logic                           bad_job
);

    localparam int CW = $clog2(MAX_JOBS + 1);
    localparam int QW = (MAX_JOBS > 1) ? $clog2(MAX_JOBS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CW-1:0] MAX_JOBS_C = CW'(MAX_JOBS);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        TERM,
        START,
        WAIT,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_nx;

    logic [INPUT_WIDTH-1:0]   queue [0:MAX_JOBS-1];

    logic [CW-1:0]            count_nx;
    logic [CW-1:0]            wr_idx;
    logic [CW-1:0]            wr_idx_nx;
    logic [CW-1:0]            idx_inc;
    logic [TW-1:0]            wait_cnt;
    logic [TW-1:0]            wait_cnt_nx;

    logic                     en_nx;
    logic [ADDR_WIDTH-1:0]    addr_nx;
    logic [INPUT_WIDTH-1:0]   data_nx;
    logic                     start_nx;
    logic                     done_nx;
    logic                     tmo_nx;
    logic                     bad_nx;
    logic                     q_we;

    // Job acceptance is only possible while idle, the queue has room, and
    // the host is not simultaneously launching the batch.
    assign job_ready = (state == IDLE) && (job_count < MAX_JOBS_C) && !batch_go;
    assign busy      = (state != IDLE);

    // Next-state and next-output logic. The memory-port, ap_start and
    // batch_done values are computed for the state being entered so that
    // they can be registered and still line up with that state.
    always_comb begin
        state_nx    = state;
        count_nx    = job_count;
        wr_idx_nx   = wr_idx;
        wait_cnt_nx = wait_cnt;
        en_nx       = 1'b0;
        addr_nx     = '0;
        data_nx     = '0;
        start_nx    = 1'b0;
        done_nx     = 1'b0;
        tmo_nx      = timeout_err;
        bad_nx      = bad_job;
        q_we        = 1'b0;
        idx_inc     = wr_idx + CW'(1);

        case (state)
            IDLE: begin
                if (batch_go) begin
                    // An empty launch is silently ignored.
                    if (job_count != '0) begin
                        state_nx  = WRITE;
                        wr_idx_nx = '0;
                        en_nx     = 1'b1;
                        addr_nx   = '0;
                        data_nx   = queue[0];
                        tmo_nx    = 1'b0;
                        bad_nx    = 1'b0;
                    end
                end else if (job_valid && job_ready) begin
                    // Zero-size jobs are dropped but remembered.
                    if (job_size == '0) begin
                        bad_nx = 1'b1;
                    end else begin
                        q_we     = 1'b1;
                        count_nx = job_count + CW'(1);
                    end
                end
            end

            WRITE: begin
                if (idx_inc < job_count) begin
                    wr_idx_nx = idx_inc;
                    en_nx     = 1'b1;
                    addr_nx   = ADDR_WIDTH'(idx_inc);
                    data_nx   = queue[QW'(idx_inc)];
                end else begin
                    // Zero terminator goes right after the last job word.
                    state_nx = TERM;
                    en_nx    = 1'b1;
                    addr_nx  = ADDR_WIDTH'(job_count);
                    data_nx  = '0;
                end
            end

            TERM: begin
                state_nx = START;
                start_nx = 1'b1;
            end

            START: begin
                state_nx    = WAIT;
                wait_cnt_nx = '0;
            end

            WAIT: begin
                // ap_done wins over a watchdog expiry on the same cycle.
                if (ap_done) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else if (wait_cnt == TMO_LAST) begin
                    state_nx = IDLE;
                    tmo_nx   = 1'b1;
                    count_nx = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + TW'(1);
                end
            end

            DONE: begin
                state_nx = IDLE;
                count_nx = '0;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counters, flags and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            job_count   <= '0;
            wr_idx      <= '0;
            wait_cnt    <= '0;
            enI         <= 1'b0;
            addrI       <= '0;
            dataI       <= '0;
            ap_start    <= 1'b0;
            batch_done  <= 1'b0;
            timeout_err <= 1'b0;
            bad_job     <= 1'b0;
        end else begin
            state       <= state_nx;
            job_count   <= count_nx;
            wr_idx      <= wr_idx_nx;
            wait_cnt    <= wait_cnt_nx;
            enI         <= en_nx;
            addrI       <= addr_nx;
            dataI       <= data_nx;
            ap_start    <= start_nx;
            batch_done  <= done_nx;
            timeout_err <= tmo_nx;
            bad_job     <= bad_nx;
        end
    end

    // Job storage; contents are only meaningful below job_count, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && q_we) begin
            queue[QW'(job_count)] <= job_size;
        end
    end

endmodule
